// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its load scoreboard.
package regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    // Bit offset of port 'port' inside a flattened vector of 'w'-bit fields.
    function automatic int port_lsb(input int port, input int w);
        return port * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Load scoreboard: one busy bit per register plus a registered count of busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [DEPTH-1:0]  busy,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ADDR_W:0]  busy_cnt_q;
    logic [ADDR_W:0]  busy_cnt_d;
    logic             set_ok;
    logic             clr_ok;
    logic             inc;
    logic             dec;

    // A set and a clear to the same register leave it busy: the new load owns it.
    always_comb begin
        set_ok = set_en && (set_addr != ADDR_W'(ZERO_REG));
        clr_ok = clr_en && (clr_addr != ADDR_W'(ZERO_REG));
        inc    = set_ok && !busy_q[set_addr];
        dec    = clr_ok && busy_q[clr_addr] && !(set_ok && (set_addr == clr_addr));

        busy_d = busy_q;
        if (clr_ok) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_d[set_addr] = 1'b1;
        end

        busy_cnt_d = busy_cnt_q + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NREAD-read register file with load scoreboard; r0 is hardwired zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and load completions to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_a,
    input  logic [ADDR_W-1:0]       wa_a,
    input  logic [WIDTH-1:0]        wd_a,
    input  logic                    we_l,
    input  logic [ADDR_W-1:0]       wa_l,
    input  logic [WIDTH-1:0]        wd_l,
    input  logic                    iss_ld,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic [NREAD-1:0]        rbusy,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              a_wr;
    logic              l_wr;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_busy;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_ld),
        .set_addr (iss_addr),
        .clr_en   (we_l),
        .clr_addr (wa_l),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // The load port is applied last so it wins a same-address collision with the ALU port.
    always_comb begin
        a_wr   = we_a && (wa_a != ADDR_W'(ZERO_REG));
        l_wr   = we_l && (wa_l != ADDR_W'(ZERO_REG));
        regs_d = regs_q;
        if (a_wr) begin
            regs_d[wa_a] = wd_a;
        end
        if (l_wr) begin
            regs_d[wa_l] = wd_l;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd      = '0;
        rbusy   = '0;
        rd_addr = '0;
        rd_data = '0;
        rd_busy = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            rd_addr = ra[port_lsb(i, ADDR_W) +: ADDR_W];
            rd_data = regs_q[rd_addr];
            rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
            // A completing load frees the register unless a new load claims it this cycle.
            if (we_l && (wa_l == rd_addr)) begin
                rd_data = wd_l;
                if (!(iss_ld && (iss_addr == rd_addr))) begin
                    rd_busy = 1'b0;
                end
            end else if (we_a && (wa_a == rd_addr)) begin
                rd_data = wd_a;
            end
`endif
            if (rd_addr == ADDR_W'(ZERO_REG)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
            rd[port_lsb(i, WIDTH) +: WIDTH] = rd_data;
            rbusy[i]                        = rd_busy;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb: a reference model pushes expected read results, sampled outputs pop them.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_l;
    logic [4:0]  wa_l;
    logic [31:0] wd_l;
    logic        iss_ld;
    logic [4:0]  iss_addr;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic [5:0]  busy_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_regs [32];
    logic        model_busy [32];
    int          checks;
    int          errors;

    regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .we_a     (we_a),
        .wa_a     (wa_a),
        .wd_a     (wd_a),
        .we_l     (we_l),
        .wa_l     (wa_l),
        .wd_l     (wd_l),
        .iss_ld   (iss_ld),
        .iss_addr (iss_addr),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we_l && wa_l == a) return wd_l;
        if (we_a && wa_a == a) return wd_a;
`endif
        return model_regs[a];
    endfunction

    function automatic logic model_rbusy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we_l && wa_l == a && !(iss_ld && iss_addr == a)) return 1'b0;
`endif
        return model_busy[a];
    endfunction

    function automatic logic [31:0] model_cnt();
        int n = 0;
        for (int k = 0; k < 32; k++) n += int'(model_busy[k]);
        return 32'(n);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            model_regs[k] = 32'h0;
            model_busy[k] = 1'b0;
        end
    endtask

    task automatic pushExpect();
        logic [4:0] a0;
        logic [4:0] a1;
        a0 = ra[4:0];
        a1 = ra[9:5];
        exp_q.push_back('{tag: $sformatf("rd0 r%0d", a0), val: model_rd(a0)});
        exp_q.push_back('{tag: $sformatf("rd1 r%0d", a1), val: model_rd(a1)});
        exp_q.push_back('{tag: $sformatf("rbusy0 r%0d", a0), val: {31'h0, model_rbusy(a0)}});
        exp_q.push_back('{tag: $sformatf("rbusy1 r%0d", a1), val: {31'h0, model_rbusy(a1)}});
        exp_q.push_back('{tag: "busy_cnt", val: model_cnt()});
    endtask

    task automatic popCheck();
        logic [31:0] obs [5];
        exp_t        e;
        obs[0] = rd[31:0];
        obs[1] = rd[63:32];
        obs[2] = {31'h0, rbusy[0]};
        obs[3] = {31'h0, rbusy[1]};
        obs[4] = {26'h0, busy_cnt};
        for (int k = 0; k < 5; k++) begin
            if (exp_q.size() == 0) begin
                checkOutput("queue_empty", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                checkOutput(e.tag, obs[k], e.val);
            end
        end
    endtask

    // One clock cycle: drive at negedge, check combinational reads mid-cycle, advance model at posedge.
    task automatic applyStimulus(input logic wea, input logic [4:0] waa, input logic [31:0] wda,
                                 input logic wel, input logic [4:0] wal, input logic [31:0] wdl,
                                 input logic iss, input logic [4:0] issa,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        @(negedge clk);
        we_a = wea; wa_a = waa; wd_a = wda;
        we_l = wel; wa_l = wal; wd_l = wdl;
        iss_ld = iss; iss_addr = issa;
        ra = {ra1, ra0};
        pushExpect();
        #2;
        popCheck();
        @(posedge clk);
        if (wea && waa != 5'd0) model_regs[waa] = wda;
        if (wel && wal != 5'd0) model_regs[wal] = wdl;
        if (wel) model_busy[wal] = 1'b0;
        if (iss && issa != 5'd0) model_busy[issa] = 1'b1;
    endtask

    task automatic idleRead(input logic [4:0] ra0, input logic [4:0] ra1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_l = 1'b0; wa_l = '0; wd_l = '0;
        iss_ld = 1'b0; iss_addr = '0; ra = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state of all registers");
        for (int k = 0; k < 16; k++) idleRead(5'(2 * k), 5'(2 * k + 1));

        $display("[TB] ALU write and read-after-write");
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        idleRead(5'd5, 5'd0);

        $display("[TB] same-address write collision");
        applyStimulus(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 5'd7, 5'd5);
        idleRead(5'd7, 5'd0);

        $display("[TB] register zero");
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        idleRead(5'd0, 5'd7);

        $display("[TB] scoreboard set/clear");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0);
        applyStimulus(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 5'd9, 5'd0);
        idleRead(5'd9, 5'd0);

        $display("[TB] random traffic");
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
        end
        for (int k = 1; k < 8; k++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(k), 32'(k * 17), 1'b0, 5'd0, 5'(k), 5'd0);
        idleRead(5'd1, 5'd2);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
        applyStimulus(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
        idleRead(5'd3, 5'd4);
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hDEAD;
        iss_ld = 1'b1; iss_addr = 5'd6;
        ra = {5'd4, 5'd3};
        rst = 1'b1;
        model_reset();
        #1;
        we_a = 1'b0;
        iss_ld = 1'b0;
        pushExpect();
        #1;
        popCheck();
        #2;
        rst = 1'b0;
        idleRead(5'd3, 5'd6);

        $display("[TB] load completion forwarding");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd4);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hBEEF, 1'b0, 5'd0, 5'd0, 5'd4);
        idleRead(5'd0, 5'd4);

        if (exp_q.size() != 0) checkOutput("queue_leftover", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
